layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Parametrised control sequencer for the conv1d / activation_cache network pipeline.
- On each sample_clk rising edge it clocks the input left shift buffers once, then walks N_LAYERS conv layers in order: reset layer, wait for its valid, clock its activation cache. It finishes with a one-cycle output strobe.
- Unlike the fixed 3-layer hand-written state machine, it adds:
  - layer count as a parameter;
  - a per-layer timeout watchdog;
  - a selectable overrun policy;
  - a return to idle after each sample;
  - busy-time and overrun statistics.

Parameters:
- N_LAYERS, 3, number of conv layers; must be >= 2.
- TIMEOUT, 1023, maximum cycles waited in RUN_LAYER before abort.
- CNT_W, 32, width of statistics counters.
- RESTART_ON_OVERRUN, 1, 1 = a new sample edge during a run restarts the sequence; 0 = the edge is dropped and the run continues.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sample_clk  in  1  sample-rate clock, synchronous to clk; its rising edge starts a sequence.
- lsb_clk  out  1  one-cycle pulse to the left shift buffers.
- layer_rst  out  N_LAYERS  one-hot, one-cycle reset/start pulse per conv layer.
- layer_out_v  in  N_LAYERS  per-layer output-valid from conv1d.
- ac_clk  out  N_LAYERS-1  one-cycle pulse to the activation cache after layer i (last layer has none).
- out_strobe  out  1  one-cycle pulse telling the output register to capture the last layer's output.
- busy  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  sticky; set on watchdog abort.
- overrun_err  out  1  sticky; set when a sample edge arrives while busy.
- last_busy_cycles  out  CNT_W  busy cycles of the last completed sequence.
- max_busy_cycles  out  CNT_W  largest last_busy_cycles value since reset.
- overrun_count  out  CNT_W  number of overrun events.

Behaviour:
- Reset (async, rst=1): state IDLE, layer index 0, prev_sample_clk 0, every output 0, every counter 0.
- Edge detect: edge = sample_clk & ~prev_sample_clk, sampled on posedge clk. prev_sample_clk is registered every cycle.
- States: IDLE, CLK_LSB, RST_LAYER, RUN_LAYER, CLK_CACHE, OUTPUT.
- All pulse outputs are Moore outputs decoded from registered state:
  - lsb_clk = (state==CLK_LSB);
  - layer_rst[i] = (state==RST_LAYER && idx==i);
  - ac_clk[i] = (state==CLK_CACHE && idx==i);
  - out_strobe = (state==OUTPUT).
- IDLE: edge -> CLK_LSB, idx=0.
- CLK_LSB -> RST_LAYER, after one cycle.
- RST_LAYER -> RUN_LAYER, after one cycle; the wait counter clears to 0.
- RUN_LAYER:
  - The first cycle is blanked: layer_out_v is ignored, so a stale valid from the previous sample is masked.
  - From the second cycle, layer_out_v[idx]=1 -> CLK_CACHE if idx<N_LAYERS-1, else OUTPUT.
  - Wait counter increments each cycle. Reaching TIMEOUT with no valid -> IDLE, timeout_err=1, no out_strobe, last_busy_cycles not updated.
- CLK_CACHE -> RST_LAYER with idx+1, after one cycle.
- OUTPUT -> IDLE, after one cycle.
- Timeline (edge sampled at cycle 0, each layer valid on its earliest accepted cycle):
  - lsb_clk at cycle 1, layer_rst[0] at 2, ac_clk[0] at 5.
  - Each layer costs 4 cycles.
  - out_strobe at cycle 4*N_LAYERS+1.
  - busy cycles = 4*N_LAYERS+1.
- Overrun (edge while state != IDLE, including the OUTPUT cycle):
  - Always: overrun_err=1 and overrun_count+1.
  - RESTART_ON_OVERRUN=1: next state CLK_LSB, idx=0; the aborted run does not update last_busy_cycles.
  - RESTART_ON_OVERRUN=0: the edge is ignored and the sequence continues.
- Simultaneous events:
  - Edge in the same cycle as a timeout: the overrun/restart rule wins. timeout_err is still set.
  - Edge in the same cycle as the OUTPUT->IDLE transition: counts as overrun. With restart, out_strobe has already fired that cycle.
- Busy counter:
  - Counts cycles with state != IDLE; saturates at 2^CNT_W-1.
  - On leaving OUTPUT: last_busy_cycles <= count and max_busy_cycles <= max(max, count), then the counter clears.
- Counter arithmetic: all counters are unsigned. overrun_count saturates. The wait counter is sized clog2(TIMEOUT+1).
- Sticky flags clear only on rst.

Optional Feature:
- Macro: LAYER_SEQUENCER_STATS_EN.
- Defined: last_busy_cycles, max_busy_cycles and overrun_count operate as described.
- Undefined: those three outputs are tied to 0 and their counter registers are not built.
- Both builds: busy, overrun_err and timeout_err are always present and unaffected.

Test Plan:
- Bench configuration: N_LAYERS=3, TIMEOUT=16, stats enabled.
- Single sample, each layer_out_v pulsed on its first accepted cycle -> lsb_clk at 1, layer_rst = 001/010/100 at 2/6/10, ac_clk[0]/[1] at 5/9, out_strobe at 13, busy for 13 cycles, last_busy_cycles=13, max_busy_cycles=13.
- layer_out_v held high constantly -> the blanked first RUN cycle is masked, and the timing equals the previous scenario; layer 0 valid never accepted at cycle 3.
- Layer 1 never valid -> abort after 16 RUN cycles, timeout_err=1, no out_strobe, busy=0 afterwards; the next edge runs normally with timeout_err still 1.
- Second edge at cycle 7 with RESTART_ON_OVERRUN=1 -> overrun_err=1, overrun_count=1, lsb_clk again at cycle 8, layer_rst[0] at 9; same stimulus with RESTART_ON_OVERRUN=0 -> out_strobe at 13, overrun_count=1.
- rst asserted asynchronously mid-RUN_LAYER (layer 1) -> all outputs 0 immediately, without waiting for clk; the next edge starts at idx 0.
- Build without LAYER_SEQUENCER_STATS_EN -> scenario 1 pulse timing identical; last_busy_cycles, max_busy_cycles and overrun_count read 0.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer
//
// Control sequencer for the conv1d / activation_cache pipeline. Each rising
// edge of sample_clk clocks the input left shift buffers once, then walks the
// conv layers in order (reset layer, wait for its valid, clock its activation
// cache) and ends with a one-cycle output strobe before returning to IDLE.
// A per-layer watchdog aborts a layer that never reports valid, and a sample
// edge arriving mid-sequence is either a restart or dropped (RESTART_ON_OVERRUN).
//
// Optional statistics: define LAYER_SEQUENCER_STATS_EN to build the busy-time
// and overrun counters. Without it, last_busy_cycles, max_busy_cycles and
// overrun_count are tied to 0.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   sample_clk        sample-rate clock (synchronous to clk); rising edge starts a run
//   lsb_clk           one-cycle pulse to the left shift buffers
//   layer_rst         one-hot, one-cycle start pulse per conv layer
//   layer_out_v       per-layer output-valid from conv1d
//   ac_clk            one-cycle pulse to the activation cache after layer i
//   out_strobe        one-cycle capture pulse for the output register
//   busy              high whenever the sequencer is not idle
//   timeout_err       sticky, set on watchdog abort
//   overrun_err       sticky, set on a sample edge while busy
//   last_busy_cycles  busy cycles of the last completed sequence
//   max_busy_cycles   largest last_busy_cycles since reset
//   overrun_count     number of overrun events (saturating)

module layer_sequencer #(
    parameter int N_LAYERS           = 3,
    parameter int TIMEOUT            = 1023,
    parameter int CNT_W              = 32,
    parameter bit RESTART_ON_OVERRUN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    output logic                lsb_clk,
    output logic [N_LAYERS-1:0] layer_rst,
    input  logic [N_LAYERS-1:0] layer_out_v,
    output logic [N_LAYERS-2:0] ac_clk,
    output logic                out_strobe,
    output logic                busy,
    output logic                timeout_err,
    output logic                overrun_err,
    output logic [CNT_W-1:0]    last_busy_cycles,
    output logic [CNT_W-1:0]    max_busy_cycles,
    output logic [CNT_W-1:0]    overrun_count
);

    localparam int IDX_W  = $clog2(N_LAYERS);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLK_LSB,
        RST_LAYER,
        RUN_LAYER,
        CLK_CACHE,
        OUTPUT
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                prev_sample_clk;

    logic sample_edge;
    logic overrun;
    logic restart;
    logic valid_seen;
    logic timed_out;
    logic last_layer;

    assign sample_edge = sample_clk & ~prev_sample_clk;
    assign overrun     = sample_edge && (state != IDLE);
    assign restart     = overrun && RESTART_ON_OVERRUN;
    // wait_cnt==0 marks the first RUN cycle, where a stale valid from the
    // previous sample may still be asserted, so it is ignored there.
    assign valid_seen  = (state == RUN_LAYER) && (wait_cnt != '0) && layer_out_v[idx];
    assign timed_out   = (state == RUN_LAYER) && !valid_seen &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign last_layer  = (idx == IDX_W'(N_LAYERS - 1));

    // Sequencer state machine; a restarting overrun pre-empts every state,
    // including a simultaneous timeout (the error flag is still recorded).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            wait_cnt        <= '0;
            prev_sample_clk <= 1'b0;
            timeout_err     <= 1'b0;
            overrun_err     <= 1'b0;
        end else begin
            prev_sample_clk <= sample_clk;
            if (overrun)   overrun_err <= 1'b1;
            if (timed_out) timeout_err <= 1'b1;

            if (restart) begin
                state <= CLK_LSB;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sample_edge) begin
                            state <= CLK_LSB;
                            idx   <= '0;
                        end
                    end
                    CLK_LSB: state <= RST_LAYER;
                    RST_LAYER: begin
                        state    <= RUN_LAYER;
                        wait_cnt <= '0;
                    end
                    RUN_LAYER: begin
                        if (valid_seen) begin
                            state <= last_layer ? OUTPUT : CLK_CACHE;
                        end else if (timed_out) begin
                            state <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    CLK_CACHE: begin
                        state <= RST_LAYER;
                        idx   <= idx + IDX_W'(1);
                    end
                    OUTPUT:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Moore pulse decode from the registered state and layer index.
    always_comb begin
        layer_rst = '0;
        ac_clk    = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            layer_rst[i] = (state == RST_LAYER) && (idx == IDX_W'(i));
        end
        for (int i = 0; i < N_LAYERS - 1; i++) begin
            ac_clk[i] = (state == CLK_CACHE) && (idx == IDX_W'(i));
        end
    end

    assign lsb_clk    = (state == CLK_LSB);
    assign out_strobe = (state == OUTPUT);
    assign busy       = (state != IDLE);

`ifdef LAYER_SEQUENCER_STATS_EN
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] busy_inc;

    // busy_inc includes the current cycle, so on the OUTPUT cycle it is the
    // full length of the sequence.
    assign busy_inc = (busy_cnt == '1) ? busy_cnt : busy_cnt + CNT_W'(1);

    // Busy-time and overrun statistics; aborted runs (restart or timeout)
    // clear the busy counter without publishing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt         <= '0;
            last_busy_cycles <= '0;
            max_busy_cycles  <= '0;
            overrun_count    <= '0;
        end else begin
            if (overrun && (overrun_count != '1)) begin
                overrun_count <= overrun_count + CNT_W'(1);
            end
            if (state == IDLE) begin
                busy_cnt <= '0;
            end else if (state == OUTPUT) begin
                last_busy_cycles <= busy_inc;
                if (busy_inc > max_busy_cycles) max_busy_cycles <= busy_inc;
                busy_cnt <= '0;
            end else if (restart || timed_out) begin
                busy_cnt <= '0;
            end else begin
                busy_cnt <= busy_inc;
            end
        end
    end
`else
    assign last_busy_cycles = '0;
    assign max_busy_cycles  = '0;
    assign overrun_count    = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Testbench for layer_sequencer: two instances (restart / drop overrun policy)
// share one stimulus stream. Scenarios come from a table; expected pulse words
// are built from the documented timeline and queued as each cycle's stimulus
// is driven, then popped and compared one cycle later.

module tb_layer_sequencer;

    localparam int NL  = 3;
    localparam int TMO = 16;
    localparam int CW  = 32;
`ifdef LAYER_SEQUENCER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_clk;
    logic [NL-1:0] layer_out_v;

    logic          lsb_a, strobe_a, busy_a, tmo_a, ovf_a;
    logic [NL-1:0] lrst_a;
    logic [NL-2:0] ac_a;
    logic [CW-1:0] last_a, max_a, ovc_a;

    logic          lsb_b, strobe_b, busy_b, tmo_b, ovf_b;
    logic [NL-1:0] lrst_b;
    logic [NL-2:0] ac_b;
    logic [CW-1:0] last_b, max_b, ovc_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] expq_a[$];
    logic [7:0] expq_b[$];

    // Scenario record: inputs (valid mode, second edge, length) and expected
    // runs (start/end/completed layers) plus the stats expected afterwards.
    typedef struct {
        string name;
        int    mode;
        int    edge2;
        int    ncyc;
        int    r0e, r0d;
        int    r1s, r1e, r1d;
        int    nre, nrd;
        int    last, maxv, ovc, ovf, tmo;
        int    nr_last, nr_ovc;
    } scen_t;

    scen_t tbl[6];

    always #5 clk = ~clk;

    layer_sequencer #(.N_LAYERS(NL), .TIMEOUT(TMO), .CNT_W(CW), .RESTART_ON_OVERRUN(1'b1)) dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk), .lsb_clk(lsb_a),
        .layer_rst(lrst_a), .layer_out_v(layer_out_v), .ac_clk(ac_a),
        .out_strobe(strobe_a), .busy(busy_a), .timeout_err(tmo_a), .overrun_err(ovf_a),
        .last_busy_cycles(last_a), .max_busy_cycles(max_a), .overrun_count(ovc_a)
    );

    layer_sequencer #(.N_LAYERS(NL), .TIMEOUT(TMO), .CNT_W(CW), .RESTART_ON_OVERRUN(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .sample_clk(sample_clk), .lsb_clk(lsb_b),
        .layer_rst(lrst_b), .layer_out_v(layer_out_v), .ac_clk(ac_b),
        .out_strobe(strobe_b), .busy(busy_b), .timeout_err(tmo_b), .overrun_err(ovf_b),
        .last_busy_cycles(last_b), .max_busy_cycles(max_b), .overrun_count(ovc_b)
    );

    // Compare one value, counting it and reporting any difference.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {busy, lsb_clk, layer_rst[2:0], ac_clk[1:0], out_strobe} in
    // cycle c for a run whose lsb_clk is at s, which is busy until e
    // (exclusive) and in which d layers completed.
    function automatic logic [7:0] runWord(input int c, input int s, input int e, input int d);
        logic [7:0] w;
        w = 8'h00;
        if (s >= 0 && c >= s && c < e) begin
            w[7] = 1'b1;
            if (c == s) w[6] = 1'b1;
            for (int i = 0; i < NL; i++)
                if (i <= d && c == s + 1 + 4 * i) w[3 + i] = 1'b1;
            for (int i = 0; i < NL - 1; i++)
                if (i < d && c == s + 4 + 4 * i) w[1 + i] = 1'b1;
            if (d == NL && c == s + 4 * NL) w[0] = 1'b1;
        end
        return w;
    endfunction

    // Drive inputs for cycle c and queue the outputs expected in cycle c+1.
    task automatic applyStimulus(input int c, input scen_t sc);
        if (c == sc.ncyc - 1) begin
            sample_clk  = 1'b0;
            layer_out_v = '0;
        end else begin
            sample_clk = (c == 0 || c == sc.edge2);
            case (sc.mode)
                0: for (int i = 0; i < NL; i++) layer_out_v[i] = (c == 4 + 4 * i);
                1: layer_out_v = '1;
                default: layer_out_v = 3'b101;
            endcase
            expq_a.push_back(runWord(c + 1, 1, sc.r0e, sc.r0d) | runWord(c + 1, sc.r1s, sc.r1e, sc.r1d));
            expq_b.push_back(runWord(c + 1, 1, sc.nre, sc.nrd));
        end
    endtask

    task automatic checkStats(input scen_t sc);
        checkOutput({sc.name, " timeout_err_a"}, 64'(tmo_a), 64'(sc.tmo));
        checkOutput({sc.name, " timeout_err_b"}, 64'(tmo_b), 64'(sc.tmo));
        checkOutput({sc.name, " overrun_err_a"}, 64'(ovf_a), 64'(sc.ovf));
        checkOutput({sc.name, " overrun_err_b"}, 64'(ovf_b), 64'(sc.ovf));
        checkOutput({sc.name, " last_busy_a"}, 64'(last_a), STATS ? 64'(sc.last) : 64'd0);
        checkOutput({sc.name, " max_busy_a"}, 64'(max_a), STATS ? 64'(sc.maxv) : 64'd0);
        checkOutput({sc.name, " overrun_count_a"}, 64'(ovc_a), STATS ? 64'(sc.ovc) : 64'd0);
        checkOutput({sc.name, " last_busy_b"}, 64'(last_b), STATS ? 64'(sc.nr_last) : 64'd0);
        checkOutput({sc.name, " overrun_count_b"}, 64'(ovc_b), STATS ? 64'(sc.nr_ovc) : 64'd0);
    endtask

    task automatic runScenario(input scen_t sc);
        logic [7:0] exp_a, exp_b;
        expq_a.delete();
        expq_b.delete();
        expq_a.push_back(8'h00);
        expq_b.push_back(8'h00);
        for (int c = 0; c < sc.ncyc; c++) begin
            @(posedge clk);
            #1;
            exp_a = expq_a.pop_front();
            exp_b = expq_b.pop_front();
            checkOutput($sformatf("%s pulses_a c%0d", sc.name, c),
                        64'({busy_a, lsb_a, lrst_a, ac_a, strobe_a}), 64'(exp_a));
            checkOutput($sformatf("%s pulses_b c%0d", sc.name, c),
                        64'({busy_b, lsb_b, lrst_b, ac_b, strobe_b}), 64'(exp_b));
            applyStimulus(c, sc);
        end
        @(posedge clk);
        #1;
        checkStats(sc);
    endtask

    initial begin
        //          name            mode e2  n   r0e d  r1s r1e d  nre d  last max ovc ovf tmo nrl nro
        tbl[0] = '{"pulse",         0,  -1, 16, 14, 3, -1, 0, 0, 14, 3, 13, 13, 0, 0, 0, 13, 0};
        tbl[1] = '{"held",          1,  -1, 16, 14, 3, -1, 0, 0, 14, 3, 13, 13, 0, 0, 0, 13, 0};
        tbl[2] = '{"timeout",       2,  -1, 26, 23, 1, -1, 0, 0, 23, 1, 13, 13, 0, 0, 1, 13, 0};
        tbl[3] = '{"after_timeout", 0,  -1, 16, 14, 3, -1, 0, 0, 14, 3, 13, 13, 0, 0, 1, 13, 0};
        tbl[4] = '{"overrun",       1,   7, 24,  8, 1,  8, 21, 3, 14, 3, 13, 13, 1, 1, 1, 13, 1};
        tbl[5] = '{"after_reset",   0,  -1, 16, 14, 3, -1, 0, 0, 14, 3, 13, 13, 0, 0, 0, 13, 0};

        rst         = 1'b1;
        sample_clk  = 1'b0;
        layer_out_v = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset pulses_a", 64'({busy_a, lsb_a, lrst_a, ac_a, strobe_a}), 64'd0);
        checkOutput("reset flags_a", 64'({tmo_a, ovf_a}), 64'd0);
        checkOutput("reset counters_a", 64'(last_a | max_a | ovc_a), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) runScenario(tbl[k]);

        // Asynchronous reset while layer 1 is running.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            sample_clk  = (c == 0);
            layer_out_v = '1;
        end
        checkOutput("pre_reset busy_a", 64'({busy_a, lsb_a, lrst_a, ac_a, strobe_a}), 64'h80);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset pulses_a", 64'({busy_a, lsb_a, lrst_a, ac_a, strobe_a}), 64'd0);
        checkOutput("async_reset pulses_b", 64'({busy_b, lsb_b, lrst_b, ac_b, strobe_b}), 64'd0);
        checkOutput("async_reset flags", 64'({tmo_a, ovf_a, tmo_b, ovf_b}), 64'd0);
        checkOutput("async_reset counters", 64'(last_a | max_a | ovc_a | last_b | max_b | ovc_b), 64'd0);
        #2;
        rst         = 1'b0;
        sample_clk  = 1'b0;
        layer_out_v = '0;
        runScenario(tbl[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
